// File: rtl/branch_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch stall/flush controller.
// Holds the FSM encoding, per-producer stall lengths and the per-operand need helper.
package branch_stall_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int NEED_W = 2;

  localparam logic [NEED_W-1:0] NEED_NONE   = 2'd0;
  localparam logic [NEED_W-1:0] NEED_ALU_EX = 2'd1;
  localparam logic [NEED_W-1:0] NEED_LD_EX  = 2'd2;
  localparam logic [NEED_W-1:0] NEED_LD_MEM = 2'd1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bubbles needed before one ID operand can be forwarded; an ALU result in MEM is already forwardable.
  function automatic logic [NEED_W-1:0] operand_need(
    input logic [4:0] i_src,
    input logic       i_rw1,
    input logic       i_mr1,
    input logic [4:0] i_rd1,
    input logic       i_rw2,
    input logic       i_mr2,
    input logic [4:0] i_rd2
  );
    logic [NEED_W-1:0] w_need;
    w_need = NEED_NONE;
    if (i_src != REG_ZERO) begin
      if (i_rw1 && i_mr1 && (i_rd1 == i_src))
        w_need = NEED_LD_EX;
      else if (i_rw1 && !i_mr1 && (i_rd1 == i_src))
        w_need = NEED_ALU_EX;
      else if (i_rw2 && i_mr2 && (i_rd2 == i_src))
        w_need = NEED_LD_MEM;
    end
    return w_need;
  endfunction

endpackage

// File: rtl/branch_stall_ctrl_if.sv
// Pipeline-facing signal bundle of the branch stall controller.
// The slave side is the controller; the master side is the pipeline (or a bench).
interface branch_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             J;
  logic             JR;
  logic             BNE;
  logic             BGTZ;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic             RW1;
  logic             MR1;
  logic [4:0]       Rd1;
  logic             RW2;
  logic             MR2;
  logic [4:0]       Rd2;
  logic             Taken;
  logic             Hold;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXFlush;
  logic             IFIDFlush;
  logic             Busy;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output J, JR, BNE, BGTZ, Rs, Rt, RW1, MR1, Rd1, RW2, MR2, Rd2, Taken, Hold,
    input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Busy, StallCnt, FlushCnt
  );

  modport slave (
    input  J, JR, BNE, BGTZ, Rs, Rt, RW1, MR1, Rd1, RW2, MR2, Rd2, Taken, Hold,
    output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Busy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/branch_stall_ctrl_need_calc.sv
// Combinational stall-length calculation for the Rs/Rt operands of a branch in ID.
// The longer of the two operand waits wins; non-branches never stall.
module branch_need_calc
  import branch_stall_ctrl_pkg::*;
(
  input  logic              i_br,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic              i_rw1,
  input  logic              i_mr1,
  input  logic [4:0]        i_rd1,
  input  logic              i_rw2,
  input  logic              i_mr2,
  input  logic [4:0]        i_rd2,
  output logic [NEED_W-1:0] o_need
);

  logic [NEED_W-1:0] w_needRs;
  logic [NEED_W-1:0] w_needRt;

  always_comb begin
    w_needRs = operand_need(i_rs, i_rw1, i_mr1, i_rd1, i_rw2, i_mr2, i_rd2);
    w_needRt = operand_need(i_rt, i_rw1, i_mr1, i_rd1, i_rw2, i_mr2, i_rd2);
    o_need   = NEED_NONE;
    if (i_br)
      o_need = (w_needRs > w_needRt) ? w_needRs : w_needRt;
  end

endmodule

// File: rtl/branch_stall_ctrl.sv
// Stall/flush controller for branches resolved in ID: freezes PC and IF/ID while an
// operand is not yet forwardable, then squashes the wrong-path fetch on a taken branch.
module branch_stall_ctrl
  import branch_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 32
) (
  input logic clk,
  input logic rst,
  branch_stall_ctrl_if.slave bus
);

  localparam int REM_W = $clog2(MAX_STALL + 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [REM_W-1:0]   r_rem;
  logic [REM_W-1:0]   w_nextRem;
  logic [CNT_W-1:0]   r_stallCnt;
  logic [CNT_W-1:0]   r_flushCnt;
  logic [NEED_W-1:0]  w_need;
  logic [NEED_W-1:0]  w_needLeft;
  logic               w_br;
  logic               w_pcWrite;
  logic               w_ifidWrite;
  logic               w_idexFlush;
  logic               w_ifidFlush;
  logic               w_stallInc;

  // J/JAL is excluded from Br: its target needs no register operand.
  assign w_br       = (!bus.J || bus.JR) && (bus.BNE || bus.JR || bus.BGTZ);
  assign w_needLeft = w_need - NEED_W'(1);

  branch_need_calc u_needCalc (
    .i_br   (w_br),
    .i_rs   (bus.Rs),
    .i_rt   (bus.Rt),
    .i_rw1  (bus.RW1),
    .i_mr1  (bus.MR1),
    .i_rd1  (bus.Rd1),
    .i_rw2  (bus.RW2),
    .i_mr2  (bus.MR2),
    .i_rd2  (bus.Rd2),
    .o_need (w_need)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_rem   <= w_nextRem;
      if (w_stallInc)
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_ifidFlush)
        r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  // Hold freezes everything; in STALL the comparator result is stale, so Taken is ignored.
  always_comb begin
    w_nextState = r_state;
    w_nextRem   = r_rem;
    w_pcWrite   = 1'b1;
    w_ifidWrite = 1'b1;
    w_idexFlush = 1'b0;
    w_ifidFlush = 1'b0;
    w_stallInc  = 1'b0;
    if (rst) begin
      w_nextState = IDLE;
      w_nextRem   = '0;
    end else if (bus.Hold) begin
      w_pcWrite   = 1'b0;
      w_ifidWrite = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_need != NEED_NONE) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexFlush = 1'b1;
            w_stallInc  = 1'b1;
            w_nextRem   = REM_W'(w_needLeft);
            if (w_needLeft != '0)
              w_nextState = STALL;
          end else begin
            w_ifidFlush = bus.Taken && (w_br || bus.J);
          end
        end
        STALL: begin
          w_pcWrite   = 1'b0;
          w_ifidWrite = 1'b0;
          w_idexFlush = 1'b1;
          w_stallInc  = 1'b1;
          w_nextRem   = r_rem - REM_W'(1);
          if (r_rem == REM_W'(1))
            w_nextState = IDLE;
        end
        default: begin
          w_nextState = IDLE;
          w_nextRem   = '0;
        end
      endcase
    end
  end

  assign bus.PCWrite   = w_pcWrite;
  assign bus.IFIDWrite = w_ifidWrite;
  assign bus.IDEXFlush = w_idexFlush;
  assign bus.IFIDFlush = w_ifidFlush;
  assign bus.Busy      = !rst && (r_state == STALL);
  assign bus.StallCnt  = r_stallCnt;
  assign bus.FlushCnt  = r_flushCnt;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed table-driven bench for branch_stall_ctrl: one table row per clock cycle,
// followed by a hand-written JR sequence covering a load-in-MEM stall and a later flush.
module tb_branch_stall_ctrl;

  localparam int CNT_W = 32;

  // Opcode groups {J, JR, BNE, BGTZ}
  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_JR   = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0010;
  localparam logic [3:0] OP_BGTZ = 4'b0001;

  // Expected outputs {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Busy}
  localparam logic [4:0] E_RUN    = 5'b11000;
  localparam logic [4:0] E_FLUSH  = 5'b11010;
  localparam logic [4:0] E_STALL  = 5'b00100;
  localparam logic [4:0] E_STALLB = 5'b00101;
  localparam logic [4:0] E_HOLD   = 5'b00000;
  localparam logic [4:0] E_HOLDB  = 5'b00001;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rw1;
    logic        mr1;
    logic [4:0]  rd1;
    logic        rw2;
    logic        mr2;
    logic [4:0]  rd2;
    logic        taken;
    logic        hold;
    logic [4:0]  exp;
    int unsigned sc;
    int unsigned fc;
  } vec_t;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFail;
  vec_t vecs[$];

  branch_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_stall_ctrl #(.MAX_STALL(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic rst_i, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
    input logic rw1, input logic mr1, input logic [4:0] rd1,
    input logic rw2, input logic mr2, input logic [4:0] rd2,
    input logic taken, input logic hold, input logic [4:0] exp,
    input int unsigned sc, input int unsigned fc);
    vec_t v;
    v.rst = rst_i; v.op = op; v.rs = rs; v.rt = rt;
    v.rw1 = rw1; v.mr1 = mr1; v.rd1 = rd1;
    v.rw2 = rw2; v.mr2 = mr2; v.rd2 = rd2;
    v.taken = taken; v.hold = hold; v.exp = exp; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    bus.J     = v.op[3];
    bus.JR    = v.op[2];
    bus.BNE   = v.op[1];
    bus.BGTZ  = v.op[0];
    bus.Rs    = v.rs;
    bus.Rt    = v.rt;
    bus.RW1   = v.rw1;
    bus.MR1   = v.mr1;
    bus.Rd1   = v.rd1;
    bus.RW2   = v.rw2;
    bus.MR2   = v.mr2;
    bus.Rd2   = v.rd2;
    bus.Taken = v.taken;
    bus.Hold  = v.hold;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    chk("PCWrite",   idx, 32'(bus.PCWrite),   32'(v.exp[4]));
    chk("IFIDWrite", idx, 32'(bus.IFIDWrite), 32'(v.exp[3]));
    chk("IDEXFlush", idx, 32'(bus.IDEXFlush), 32'(v.exp[2]));
    chk("IFIDFlush", idx, 32'(bus.IFIDFlush), 32'(v.exp[1]));
    chk("Busy",      idx, 32'(bus.Busy),      32'(v.exp[0]));
    chk("StallCnt",  idx, bus.StallCnt,       v.sc);
    chk("FlushCnt",  idx, bus.FlushCnt,       v.fc);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic runRow(input vec_t v, input int idx);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    //             rst op        rs  rt  rw1 mr1 rd1 rw2 mr2 rd2 tk hd exp       sc  fc
    vecs.push_back(mk(1, OP_BNE,  5,  0, 1, 0,  5, 0, 0,  0, 0, 0, E_RUN,    0, 0));
    vecs.push_back(mk(1, OP_J,    0,  0, 0, 0,  0, 0, 0,  0, 1, 0, E_RUN,    0, 0));
    vecs.push_back(mk(0, OP_BNE,  5,  0, 1, 0,  5, 0, 0,  0, 0, 0, E_STALL,  0, 0));
    vecs.push_back(mk(0, OP_BNE,  5,  0, 1, 0,  0, 0, 0,  0, 0, 0, E_RUN,    1, 0));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 1, 1,  8, 0, 0,  0, 0, 0, E_STALL,  1, 0));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 1, 0, E_STALLB, 2, 0));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 0,  8, 0, 0, E_RUN,    3, 0));
    vecs.push_back(mk(0, OP_BNE,  3,  9, 0, 0,  0, 1, 1,  9, 0, 0, E_STALL,  3, 0));
    vecs.push_back(mk(0, OP_BNE,  3,  0, 0, 0,  0, 1, 1,  0, 0, 0, E_RUN,    4, 0));
    vecs.push_back(mk(0, OP_NONE, 5,  0, 1, 1,  5, 0, 0,  0, 1, 0, E_RUN,    4, 0));
    vecs.push_back(mk(0, OP_BNE,  7,  0, 0, 0,  0, 1, 0,  7, 0, 0, E_RUN,    4, 0));
    vecs.push_back(mk(0, OP_BNE,  4,  6, 1, 1,  6, 1, 1,  4, 0, 0, E_STALL,  4, 0));
    vecs.push_back(mk(0, OP_NONE, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, E_STALLB, 5, 0));
    vecs.push_back(mk(0, OP_JR,  31,  0, 0, 0,  0, 0, 0,  0, 1, 0, E_FLUSH,  6, 0));
    vecs.push_back(mk(0, OP_J,    0,  0, 0, 0,  0, 0, 0,  0, 1, 0, E_FLUSH,  6, 1));
    vecs.push_back(mk(0, OP_J,    0,  0, 0, 0,  0, 0, 0,  0, 0, 0, E_RUN,    6, 2));
    vecs.push_back(mk(0, OP_BNE,  1,  2, 0, 0,  0, 0, 0,  0, 1, 0, E_FLUSH,  6, 2));
    vecs.push_back(mk(0, OP_BNE,  2,  0, 1, 0,  2, 0, 0,  0, 1, 0, E_STALL,  6, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 1, 1,  8, 0, 0,  0, 0, 0, E_STALL,  7, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 1, 1, E_HOLDB,  8, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 1, 1, E_HOLDB,  8, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 1, 1, E_HOLDB,  8, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 0, 0, E_STALLB, 8, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 0, 0,  0, 0, 0,  0, 0, 0, E_RUN,    9, 3));
    vecs.push_back(mk(0, OP_BNE,  5,  0, 1, 0,  5, 0, 0,  0, 1, 1, E_HOLD,   9, 3));
    vecs.push_back(mk(0, OP_BNE,  5,  0, 1, 0,  5, 0, 0,  0, 1, 0, E_STALL,  9, 3));
    vecs.push_back(mk(0, OP_BGTZ, 8,  0, 1, 1,  8, 0, 0,  0, 0, 0, E_STALL, 10, 3));
    vecs.push_back(mk(1, OP_BGTZ, 8,  0, 0, 0,  0, 1, 1,  8, 1, 0, E_RUN,   11, 3));
    vecs.push_back(mk(0, OP_NONE, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, E_RUN,    0, 0));

    for (int i = 0; i < vecs.size(); i++)
      runRow(vecs[i], i);

    // JR waiting on a load in MEM: one bubble, then the taken jump squashes IF/ID.
    runRow(mk(0, OP_JR, 31, 0, 0, 0, 0, 1, 1, 31, 1, 0, E_STALL, 0, 0), 100);
    runRow(mk(0, OP_JR, 31, 0, 0, 0, 0, 0, 0,  0, 1, 0, E_FLUSH, 1, 0), 101);
    runRow(mk(0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   1, 1), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
